// File: rtl/mem_stage_pkg.sv
// Shared encodings and lane helpers for the memory-access stage.
// Imported by the top and the load-alignment block.
package mem_stage_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {IDLE, ACCESS} state_e;

    function automatic logic [3:0] byte_enable(input logic [1:0] addr_lo,
                                               input logic [1:0] size,
                                               input logic       big_endian);
        logic [1:0] lane;
        logic       pair;
        lane = big_endian ? (2'd3 - addr_lo) : addr_lo;
        pair = addr_lo[1] ^ big_endian;
        case (size)
            SZ_BYTE: byte_enable = 4'b0001 << lane;
            SZ_HALF: byte_enable = pair ? 4'b1100 : 4'b0011;
            default: byte_enable = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [31:0] wdata,
                                              input logic [1:0]  size);
        case (size)
            SZ_BYTE: replicate = {4{wdata[7:0]}};
            SZ_HALF: replicate = {2{wdata[15:0]}};
            default: replicate = wdata;
        endcase
    endfunction

    // Size 2'b11 is an alias of word, so any size with bit 1 set needs word alignment.
    function automatic logic misaligned(input logic [1:0] addr_lo,
                                        input logic [1:0] size);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = addr_lo[0];
            default: misaligned = (addr_lo != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Picks the addressed byte/half lane out of a memory word and
// sign- or zero-extends it to 32 bits.
module load_align
    import mem_stage_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [1:0]  size_i,
    input  logic        signext_i,
    output logic [31:0] data_o
);

    logic [1:0]  lane;
    logic        pair;
    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    always_comb begin
        lane    = BIG_ENDIAN ? (2'd3 - addr_i) : addr_i;
        pair    = addr_i[1] ^ BIG_ENDIAN;
        byteVal = rdata_i[{lane, 3'b000} +: 8];
        halfVal = rdata_i[{pair, 4'b0000} +: 16];
        case (size_i)
            SZ_BYTE: data_o = {{24{signext_i & byteVal[7]}}, byteVal};
            SZ_HALF: data_o = {{16{signext_i & halfVal[15]}}, halfVal};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: byte/half/word loads and stores over a req/ack data port,
// stalling EX while busy, with misalignment and bus-timeout reporting.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W         = 12,
    parameter bit BIG_ENDIAN     = 1'b0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_read,
    input  logic              in_write,
    input  logic [1:0]        in_size,
    input  logic              in_signext,
    input  logic              in_jal,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_wdata,
    input  logic [31:0]       in_pc4,
    input  logic [31:0]       in_next_pc,
    input  logic              in_int_choose,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [31:0]       wb_rf_din,
    output logic [31:0]       wb_next_pc,
    output logic [31:0]       wb_pc4,
    output logic              wb_int_choose,
    output logic              wb_misalign,
    output logic              wb_bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   reqAddr_q, reqAddr_d;
    logic                reqWe_q, reqWe_d;
    logic [3:0]          reqBe_q, reqBe_d;
    logic [31:0]         reqWdata_q, reqWdata_d;
    logic [1:0]          reqLo_q, reqLo_d;
    logic [1:0]          reqSize_q, reqSize_d;
    logic                reqSext_q, reqSext_d;
    logic [31:0]         reqPc4_q, reqPc4_d;
    logic [31:0]         reqNextPc_q, reqNextPc_d;
    logic                reqInt_q, reqInt_d;
    logic                wbValid_q, wbValid_d;
    logic [31:0]         wbRf_q, wbRf_d;
    logic [31:0]         wbNextPc_q, wbNextPc_d;
    logic [31:0]         wbPc4_q, wbPc4_d;
    logic                wbInt_q, wbInt_d;
    logic                wbMis_q, wbMis_d;
    logic                wbErr_q, wbErr_d;

    logic                memOp;
    logic                inMisaligned;
    logic [31:0]         loadValue;

    load_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_load_align (
        .rdata_i   (mem_rdata),
        .addr_i    (reqLo_q),
        .size_i    (reqSize_q),
        .signext_i (reqSext_q),
        .data_o    (loadValue)
    );

    assign memOp        = in_read | in_write;
    assign inMisaligned = misaligned(in_addr[1:0], in_size);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        reqAddr_d   = reqAddr_q;
        reqWe_d     = reqWe_q;
        reqBe_d     = reqBe_q;
        reqWdata_d  = reqWdata_q;
        reqLo_d     = reqLo_q;
        reqSize_d   = reqSize_q;
        reqSext_d   = reqSext_q;
        reqPc4_d    = reqPc4_q;
        reqNextPc_d = reqNextPc_q;
        reqInt_d    = reqInt_q;
        wbValid_d   = 1'b0;
        wbRf_d      = wbRf_q;
        wbNextPc_d  = wbNextPc_q;
        wbPc4_d     = wbPc4_q;
        wbInt_d     = wbInt_q;
        wbMis_d     = wbMis_q;
        wbErr_d     = wbErr_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!memOp || inMisaligned) begin
                        wbValid_d  = 1'b1;
                        wbRf_d     = memOp ? 32'h0 : (in_jal ? in_pc4 : in_addr);
                        wbNextPc_d = in_next_pc;
                        wbPc4_d    = in_pc4;
                        wbInt_d    = in_int_choose;
                        wbMis_d    = memOp;
                        wbErr_d    = 1'b0;
                    end else begin
                        state_d     = ACCESS;
                        cnt_d       = '0;
                        reqAddr_d   = {in_addr[ADDR_W-1:2], 2'b00};
                        reqWe_d     = in_write;
                        reqBe_d     = byte_enable(in_addr[1:0], in_size, BIG_ENDIAN);
                        reqWdata_d  = replicate(in_wdata, in_size);
                        reqLo_d     = in_addr[1:0];
                        reqSize_d   = in_size;
                        reqSext_d   = in_signext;
                        reqPc4_d    = in_pc4;
                        reqNextPc_d = in_next_pc;
                        reqInt_d    = in_int_choose;
                    end
                end
            end
            ACCESS: begin
                // An ack arriving on the last allowed cycle still completes normally.
                if (mem_ack || cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = IDLE;
                    wbValid_d  = 1'b1;
                    wbRf_d     = (mem_ack && !reqWe_q) ? loadValue : 32'h0;
                    wbNextPc_d = reqNextPc_q;
                    wbPc4_d    = reqPc4_q;
                    wbInt_d    = reqInt_q;
                    wbMis_d    = 1'b0;
                    wbErr_d    = !mem_ack;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            reqAddr_q   <= '0;
            reqWe_q     <= 1'b0;
            reqBe_q     <= 4'h0;
            reqWdata_q  <= 32'h0;
            reqLo_q     <= 2'b00;
            reqSize_q   <= 2'b00;
            reqSext_q   <= 1'b0;
            reqPc4_q    <= 32'h0;
            reqNextPc_q <= 32'h0;
            reqInt_q    <= 1'b0;
            wbValid_q   <= 1'b0;
            wbRf_q      <= 32'h0;
            wbNextPc_q  <= 32'h0;
            wbPc4_q     <= 32'h0;
            wbInt_q     <= 1'b0;
            wbMis_q     <= 1'b0;
            wbErr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            reqAddr_q   <= reqAddr_d;
            reqWe_q     <= reqWe_d;
            reqBe_q     <= reqBe_d;
            reqWdata_q  <= reqWdata_d;
            reqLo_q     <= reqLo_d;
            reqSize_q   <= reqSize_d;
            reqSext_q   <= reqSext_d;
            reqPc4_q    <= reqPc4_d;
            reqNextPc_q <= reqNextPc_d;
            reqInt_q    <= reqInt_d;
            wbValid_q   <= wbValid_d;
            wbRf_q      <= wbRf_d;
            wbNextPc_q  <= wbNextPc_d;
            wbPc4_q     <= wbPc4_d;
            wbInt_q     <= wbInt_d;
            wbMis_q     <= wbMis_d;
            wbErr_q     <= wbErr_d;
        end
    end

    assign mem_req       = (state_q == ACCESS);
    assign mem_we        = mem_req & reqWe_q;
    assign mem_addr      = reqAddr_q;
    assign mem_wdata     = reqWdata_q;
    assign mem_be        = reqBe_q;
    assign stall         = (state_q == ACCESS) ||
                           (in_valid && memOp && !inMisaligned);
    assign wb_valid      = wbValid_q;
    assign wb_rf_din     = wbRf_q;
    assign wb_next_pc    = wbNextPc_q;
    assign wb_pc4        = wbPc4_q;
    assign wb_int_choose = wbInt_q;
    assign wb_misalign   = wbMis_q;
    assign wb_bus_err    = wbErr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: vector table plus scoreboard of writebacks,
// hand-written reset/back-to-back/stray-ack sequences, and a big-endian lane table.
module tb_mem_access_stage;

    localparam int TMO = 4;

    logic        clk, rst;
    logic        in_valid, in_read, in_write, in_signext, in_jal, in_int_choose;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata, in_pc4, in_next_pc;
    logic        stall, mem_req, mem_we, mem_ack;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        wb_valid, wb_int_choose, wb_misalign, wb_bus_err;
    logic [31:0] wb_rf_din, wb_next_pc, wb_pc4;

    logic [31:0] beRdata, beData;
    logic [1:0]  beAddr, beSize;
    logic        beSext;

    mem_access_stage #(.ADDR_W(12), .BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_read(in_read), .in_write(in_write),
        .in_size(in_size), .in_signext(in_signext), .in_jal(in_jal), .in_addr(in_addr),
        .in_wdata(in_wdata), .in_pc4(in_pc4), .in_next_pc(in_next_pc),
        .in_int_choose(in_int_choose), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rf_din(wb_rf_din),
        .wb_next_pc(wb_next_pc), .wb_pc4(wb_pc4), .wb_int_choose(wb_int_choose),
        .wb_misalign(wb_misalign), .wb_bus_err(wb_bus_err)
    );

    load_align #(.BIG_ENDIAN(1'b1)) beAlign (
        .rdata_i(beRdata), .addr_i(beAddr), .size_i(beSize), .signext_i(beSext), .data_o(beData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rf;
        logic        mis;
        logic        err;
        logic [31:0] pc4;
        logic [31:0] nextPc;
        logic        intc;
    } exp_t;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  size;
        logic        sx;
        logic        jal;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [31:0] pc4;
        int          ackDelay;
        logic [31:0] expRf;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic        expMis;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic [1:0]  addr;
        logic [1:0]  size;
        logic        sx;
        logic [31:0] rdata;
        logic [31:0] exp;
    } be_vec_t;

    exp_t    expQ[$];
    vec_t    vecs[15];
    be_vec_t beVecs[6];
    int      nChecks = 0;
    int      nPass   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Scoreboard: every writeback pulse is matched against the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && wb_valid) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedWb", {31'b0, wb_valid}, 32'h0);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("wbRfDin", wb_rf_din, e.rf);
                checkOutput("wbMisalign", {31'b0, wb_misalign}, {31'b0, e.mis});
                checkOutput("wbBusErr", {31'b0, wb_bus_err}, {31'b0, e.err});
                checkOutput("wbPc4", wb_pc4, e.pc4);
                checkOutput("wbNextPc", wb_next_pc, e.nextPc);
                checkOutput("wbIntChoose", {31'b0, wb_int_choose}, {31'b0, e.intc});
            end
        end
    end

    task automatic waitDrain();
        for (int c = 0; c < 4 && expQ.size() != 0; c++) @(negedge clk);
        if (expQ.size() != 0) begin
            checkOutput("wbTimeout", expQ.size(), 32'h0);
            expQ.delete();
        end
    endtask

    task automatic driveOp(input logic rd, input logic wr, input logic [1:0] size, input logic sx,
                           input logic jal, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] pc4, input logic intc);
        in_read = rd; in_write = wr; in_size = size; in_signext = sx; in_jal = jal;
        in_addr = addr; in_wdata = wdata; in_pc4 = pc4; in_next_pc = pc4 + 32'h100;
        in_int_choose = intc; in_valid = 1'b1;
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        logic goesToMem;
        goesToMem = (v.rd | v.wr) & ~v.expMis;
        e.rf = v.expRf; e.mis = v.expMis; e.err = v.expErr;
        e.pc4 = v.pc4; e.nextPc = v.pc4 + 32'h100; e.intc = idx[0];
        @(negedge clk);
        driveOp(v.rd, v.wr, v.size, v.sx, v.jal, v.addr, v.wdata, v.pc4, idx[0]);
        expQ.push_back(e);
        #1;
        checkOutput($sformatf("stallAccept[%0d]", idx), {31'b0, stall}, {31'b0, goesToMem});
        @(negedge clk);
        if (goesToMem) begin
            checkOutput($sformatf("memReq[%0d]", idx), {31'b0, mem_req}, 32'h1);
            checkOutput($sformatf("memAddr[%0d]", idx), {20'b0, mem_addr}, {20'b0, v.addr[11:2], 2'b00});
            checkOutput($sformatf("memWe[%0d]", idx), {31'b0, mem_we}, {31'b0, v.wr});
            checkOutput($sformatf("memBe[%0d]", idx), {28'b0, mem_be}, {28'b0, v.expBe});
            if (v.wr) checkOutput($sformatf("memWdata[%0d]", idx), mem_wdata, v.expWdata);
            for (int c = 1; c <= TMO; c++) begin
                if (c > 1) @(negedge clk);
                if (v.ackDelay == c - 1) begin
                    mem_ack = 1'b1;
                    mem_rdata = v.rdata;
                    checkOutput($sformatf("stallAck[%0d]", idx), {31'b0, stall}, 32'h1);
                    break;
                end
                if (c == TMO) checkOutput($sformatf("memReqHeld[%0d]", idx), {31'b0, mem_req}, 32'h1);
            end
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = 32'h5A5A5A5A;
            in_valid = 1'b0;
            #1;
            checkOutput($sformatf("memReqDone[%0d]", idx), {31'b0, mem_req}, 32'h0);
            checkOutput($sformatf("stallDone[%0d]", idx), {31'b0, stall}, 32'h0);
        end else begin
            checkOutput($sformatf("memReqNone[%0d]", idx), {31'b0, mem_req}, 32'h0);
            in_valid = 1'b0;
        end
        waitDrain();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //           rd wr size  sx jal addr          wdata         rdata         pc4           dly expRf         be    expWdata      mis err
        vecs[0]  = '{1, 0, 2'b10, 0, 0, 32'h00000104, 32'h0,        32'hDEADBEEF, 32'h00400004, 0,  32'hDEADBEEF, 4'hF, 32'h0,        0, 0};
        vecs[1]  = '{1, 0, 2'b00, 1, 0, 32'h00000003, 32'h0,        32'h80FF7F01, 32'h00400008, 2,  32'hFFFFFF80, 4'h8, 32'h0,        0, 0};
        vecs[2]  = '{1, 0, 2'b00, 0, 0, 32'h00000001, 32'h0,        32'h80FF7F01, 32'h0040000C, 1,  32'h0000007F, 4'h2, 32'h0,        0, 0};
        vecs[3]  = '{1, 0, 2'b01, 1, 0, 32'h00000002, 32'h0,        32'h80FF7F01, 32'h00400010, 0,  32'hFFFF80FF, 4'hC, 32'h0,        0, 0};
        vecs[4]  = '{1, 0, 2'b01, 0, 0, 32'h00000000, 32'h0,        32'h80FF7F01, 32'h00400014, 0,  32'h00007F01, 4'h3, 32'h0,        0, 0};
        vecs[5]  = '{0, 1, 2'b01, 0, 0, 32'h00000002, 32'h0000ABCD, 32'h0,        32'h00400018, 0,  32'h0,        4'hC, 32'hABCDABCD, 0, 0};
        vecs[6]  = '{0, 1, 2'b00, 0, 0, 32'h00000001, 32'h123456A5, 32'h0,        32'h0040001C, 1,  32'h0,        4'h2, 32'hA5A5A5A5, 0, 0};
        vecs[7]  = '{0, 1, 2'b11, 0, 0, 32'h00000008, 32'hCAFEF00D, 32'h0,        32'h00400020, 0,  32'h0,        4'hF, 32'hCAFEF00D, 0, 0};
        vecs[8]  = '{0, 0, 2'b10, 0, 1, 32'h00001234, 32'h0,        32'h0,        32'h00400008, 0,  32'h00400008, 4'h0, 32'h0,        0, 0};
        vecs[9]  = '{0, 0, 2'b10, 0, 0, 32'h12345678, 32'h0,        32'h0,        32'h00400028, 0,  32'h12345678, 4'h0, 32'h0,        0, 0};
        vecs[10] = '{1, 0, 2'b10, 0, 0, 32'h00000005, 32'h0,        32'h0,        32'h0040002C, 0,  32'h0,        4'h0, 32'h0,        1, 0};
        vecs[11] = '{1, 0, 2'b01, 1, 0, 32'h00000003, 32'h0,        32'h0,        32'h00400030, 0,  32'h0,        4'h0, 32'h0,        1, 0};
        vecs[12] = '{1, 0, 2'b10, 0, 0, 32'h00000020, 32'h0,        32'h11111111, 32'h00400034, -1, 32'h0,        4'hF, 32'h0,        0, 1};
        vecs[13] = '{1, 0, 2'b10, 0, 0, 32'h00000024, 32'h0,        32'h01020304, 32'h00400038, 3,  32'h01020304, 4'hF, 32'h0,        0, 0};
        vecs[14] = '{1, 0, 2'b10, 0, 0, 32'hABCD0FFC, 32'h0,        32'h55AA55AA, 32'h0040003C, 1,  32'h55AA55AA, 4'hF, 32'h0,        0, 0};

        beVecs[0] = '{2'd3, 2'b00, 1, 32'h80FF7F01, 32'h00000001};
        beVecs[1] = '{2'd0, 2'b00, 1, 32'h80FF7F01, 32'hFFFFFF80};
        beVecs[2] = '{2'd0, 2'b01, 0, 32'h80FF7F01, 32'h000080FF};
        beVecs[3] = '{2'd2, 2'b01, 1, 32'h80FF7F01, 32'h00007F01};
        beVecs[4] = '{2'd1, 2'b00, 0, 32'h80FF7F01, 32'h000000FF};
        beVecs[5] = '{2'd0, 2'b10, 1, 32'h80FF7F01, 32'h80FF7F01};

        rst = 1'b1; in_valid = 1'b0; in_read = 1'b0; in_write = 1'b0; in_size = 2'b00;
        in_signext = 1'b0; in_jal = 1'b0; in_addr = 32'h0; in_wdata = 32'h0; in_pc4 = 32'h0;
        in_next_pc = 32'h0; in_int_choose = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h5A5A5A5A;
        beRdata = 32'h0; beAddr = 2'b00; beSize = 2'b00; beSext = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rstMemReq", {31'b0, mem_req}, 32'h0);
        checkOutput("rstMemWe", {31'b0, mem_we}, 32'h0);
        checkOutput("rstMemAddr", {20'b0, mem_addr}, 32'h0);
        checkOutput("rstMemBe", {28'b0, mem_be}, 32'h0);
        checkOutput("rstMemWdata", mem_wdata, 32'h0);
        checkOutput("rstWbValid", {31'b0, wb_valid}, 32'h0);
        checkOutput("rstWbRfDin", wb_rf_din, 32'h0);
        checkOutput("rstStall", {31'b0, stall}, 32'h0);

        for (int i = 0; i < 15; i++) applyStimulus(vecs[i], i);

        // A stray ack while idle must not produce a writeback.
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("strayAckReq", {31'b0, mem_req}, 32'h0);
        @(negedge clk);
        checkOutput("strayAckWb", {31'b0, wb_valid}, 32'h0);

        // Reset in the second request cycle discards the pending load.
        @(negedge clk);
        driveOp(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h00000040, 32'h0, 32'h00400100, 1'b0);
        @(negedge clk);
        checkOutput("rstSeqReq", {31'b0, mem_req}, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        checkOutput("rstSeqReqDrop", {31'b0, mem_req}, 32'h0);
        checkOutput("rstSeqNoWb", {31'b0, wb_valid}, 32'h0);
        checkOutput("rstSeqStall", {31'b0, stall}, 32'h0);
        applyStimulus(vecs[0], 0);

        // Back-to-back: a jal is accepted in the same cycle the load writes back.
        @(negedge clk);
        driveOp(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h00000060, 32'h0, 32'h00400200, 1'b1);
        expQ.push_back('{32'h11223344, 1'b0, 1'b0, 32'h00400200, 32'h00400300, 1'b1});
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = 32'h11223344;
        @(negedge clk);
        mem_ack = 1'b0;
        driveOp(1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h00000777, 32'h0, 32'h00400300, 1'b0);
        expQ.push_back('{32'h00400300, 1'b0, 1'b0, 32'h00400300, 32'h00400400, 1'b0});
        #1;
        checkOutput("b2bStall", {31'b0, stall}, 32'h0);
        checkOutput("b2bWbValid", {31'b0, wb_valid}, 32'h1);
        @(negedge clk);
        in_valid = 1'b0;
        waitDrain();

        for (int i = 0; i < 6; i++) begin
            beRdata = beVecs[i].rdata; beAddr = beVecs[i].addr;
            beSize = beVecs[i].size; beSext = beVecs[i].sx;
            #1;
            checkOutput($sformatf("bigEndianLoad[%0d]", i), beData, beVecs[i].exp);
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboardEmpty", expQ.size(), 32'h0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
